// File: rtl/if_stage.sv
// Instruction fetch: PC register, combinational-read instruction memory and the IF/ID register.
// Latency: the word at pc appears on IF_ID_instr one edge later; redirects flush IF/ID to a NOP.
// Backpressure: enable=0 freezes all state, write_pc=0 holds the PC, stall_ID=1 holds IF/ID.
module if_stage #(
    parameter int              NB         = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [NB-1:0]   HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          write_pc,
    input  logic                          stall_ID,
    input  logic                          branch_taken,
    input  logic [NB-1:0]                 branch_target,
    input  logic                          jump,
    input  logic [NB-1:0]                 jump_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [NB-1:0]                 imem_wdata,
    output logic [NB-1:0]                 pc,
    output logic [NB-1:0]                 IF_ID_instr,
    output logic [NB-1:0]                 IF_ID_pc4,
    output logic                          halted
);

    localparam int            AW      = $clog2(IMEM_DEPTH);
    localparam logic [NB-1:0] PC_STEP = NB'(4);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    logic [NB-1:0] imem [IMEM_DEPTH];

    state_e        state_q, state_d;
    logic [NB-1:0] pc_q, pc_d;
    logic [NB-1:0] instr_q, instr_d;
    logic [NB-1:0] pc4_q, pc4_d;
    logic          halted_q, halted_d;

    logic [NB-1:0] fetch_word;
    logic [NB-1:0] pc_plus4;

    // Read sees the pre-write contents, so a same-cycle load shows up one cycle later.
    assign fetch_word = imem[pc_q[AW+1:2]];
    assign pc_plus4   = pc_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        halted_d = halted_q;
        if (enable) begin
            case (state_q)
                ST_RUN: begin
                    if (jump || branch_taken) begin
                        pc_d    = jump ? jump_target : branch_target;
                        instr_d = '0;
                        pc4_d   = '0;
                    end else if ((fetch_word == HALT_WORD) && !stall_ID) begin
                        instr_d  = fetch_word;
                        pc4_d    = pc_plus4;
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        if (write_pc) begin
                            pc_d = pc_plus4;
                        end
                        if (!stall_ID) begin
                            instr_d = fetch_word;
                            pc4_d   = pc_plus4;
                        end
                    end
                end
                ST_HALTED: begin
                    // Drain: HALT reaches ID once, then bubbles follow.
                    if (!stall_ID) begin
                        instr_d = '0;
                        pc4_d   = '0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            instr_q  <= '0;
            pc4_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            halted_q <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign IF_ID_instr = instr_q;
    assign IF_ID_pc4   = pc4_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: vector tables, hand-written corner sequences and a random run against a reference model.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0, write_pc = 1'b1, stall_ID = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] pc, IF_ID_instr, IF_ID_pc4;
    logic        halted;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write_pc(write_pc), .stall_ID(stall_ID),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural state only.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_halted;

    typedef struct {
        logic        en, wpc, stl, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_h;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t mkv(logic en, logic wpc, logic stl, logic br, logic [31:0] bt,
                                 logic jmp, logic [31:0] jt, logic [31:0] e_pc,
                                 logic [31:0] e_instr, logic [31:0] e_pc4, logic e_h);
        vec_t v;
        v.en = en; v.wpc = wpc; v.stl = stl; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_h = e_h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_h);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".instr"}, IF_ID_instr, e_instr);
        chk({tag, ".pc4"}, IF_ID_pc4, e_pc4);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_h});
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_halted = 1'b0;
    endtask

    // Applies the fetch rules to the inputs currently driven, before the edge.
    task automatic model_step();
        logic [31:0] f;
        f = m_mem[m_pc[9:2]];
        if (enable) begin
            if (m_halted) begin
                if (!stall_ID) begin m_instr = '0; m_pc4 = '0; end
            end else if (jump || branch_taken) begin
                m_pc = jump ? jump_target : branch_target;
                m_instr = '0; m_pc4 = '0;
            end else if (f == HALT && !stall_ID) begin
                m_instr = f; m_pc4 = m_pc + 32'd4; m_halted = 1'b1;
            end else begin
                if (!stall_ID) begin m_instr = f; m_pc4 = m_pc + 32'd4; end
                if (write_pc) m_pc = m_pc + 32'd4;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        enable = 1'b0; write_pc = 1'b1; stall_ID = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; imem_we = 1'b0;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        set_idle();
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        enable = v.en; write_pc = v.wpc; stall_ID = v.stl;
        branch_taken = v.br; branch_target = v.bt; jump = v.jmp; jump_target = v.jt;
        imem_we = 1'b0;
        tick();
    endtask

    // Asserts reset mid-cycle and checks the outputs clear before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk_all(tag, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 256; i++) mem_write(8'(i), 32'h1000_0000 | i);
        mem_write(8'd0, 32'h20010005);
        mem_write(8'd1, 32'h20020007);
        mem_write(8'd2, HALT);
        chk_all("load_idle", 32'h0, 32'h0, 32'h0, 1'b0);

        tbl1.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h4, 32'h20010005, 32'h4, 0));
        tbl1.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h20020007, 32'h8, 0));
        tbl1.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h8, HALT, 32'hC, 1));
        tbl1.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h0, 32'h0, 1));
        tbl1.push_back(mkv(1, 1, 0, 0, 0, 1, 32'h80, 32'h8, 32'h0, 32'h0, 1));
        foreach (tbl1[i]) begin
            apply(tbl1[i]);
            chk_all($sformatf("t1_%0d", i), tbl1[i].e_pc, tbl1[i].e_instr, tbl1[i].e_pc4, tbl1[i].e_h);
        end

        do_reset("rst_halted");
        mem_write(8'd2, 32'h20030009);
        chk_all("after_rst", 32'h0, 32'h0, 32'h0, 1'b0);

        tbl2.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h4, 32'h20010005, 32'h4, 0));
        tbl2.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h20020007, 32'h8, 0));
        tbl2.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 32'h8, 32'h20020007, 32'h8, 0));
        tbl2.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 32'h8, 32'h20020007, 32'h8, 0));
        tbl2.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'hC, 32'h20030009, 32'hC, 0));
        tbl2.push_back(mkv(1, 1, 1, 1, 32'h40, 0, 0, 32'h40, 32'h0, 32'h0, 0));
        tbl2.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h44, 32'h1000_0010, 32'h44, 0));
        tbl2.push_back(mkv(1, 1, 0, 1, 32'h40, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0));
        tbl2.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 32'h84, 32'h1000_0020, 32'h84, 0));
        tbl2.push_back(mkv(0, 1, 0, 1, 32'h40, 0, 0, 32'h84, 32'h1000_0020, 32'h84, 0));
        foreach (tbl2[i]) begin
            apply(tbl2[i]);
            chk_all($sformatf("t2_%0d", i), tbl2[i].e_pc, tbl2[i].e_instr, tbl2[i].e_pc4, tbl2[i].e_h);
        end

        // Three frozen cycles while loading, then one step picks up the new word.
        mem_write(8'd33, 32'hABCD0001);
        mem_write(8'd34, 32'hABCD0002);
        mem_write(8'd35, 32'hABCD0003);
        chk_all("frozen", 32'h84, 32'h1000_0020, 32'h84, 1'b0);
        set_idle(); enable = 1'b1;
        tick();
        chk_all("step", 32'h88, 32'hABCD0001, 32'h88, 1'b0);

        // Same-cycle write to the fetched word returns the old contents.
        enable = 1'b1; imem_we = 1'b1; imem_waddr = 8'd34; imem_wdata = 32'h5555_0000;
        tick();
        imem_we = 1'b0;
        chk_all("rd_old", 32'h8C, 32'hABCD0002, 32'h8C, 1'b0);

        // HALT fetched under stall waits, then halts once the stall lifts.
        mem_write(8'd35, HALT);
        set_idle(); enable = 1'b1; write_pc = 1'b0; stall_ID = 1'b1;
        tick();
        chk_all("halt_stall", 32'h8C, 32'hABCD0002, 32'h8C, 1'b0);
        write_pc = 1'b1; stall_ID = 1'b0;
        tick();
        chk_all("halt_go", 32'h8C, HALT, 32'h90, 1'b1);
        stall_ID = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        chk_all("halt_hold", 32'h8C, HALT, 32'h90, 1'b1);
        stall_ID = 1'b0; branch_taken = 1'b0;
        tick();
        chk_all("halt_drain", 32'h8C, 32'h0, 32'h0, 1'b1);
        do_reset("rst2");

        // Random run against the reference model.
        for (int i = 0; i < 256; i++)
            mem_write(8'(i), ($urandom_range(0, 29) == 0) ? HALT : $urandom);
        begin
            int halt_cycles;
            halt_cycles = 0;
            for (int c = 0; c < 1500; c++) begin
                enable        = ($urandom_range(0, 9) < 8);
                write_pc      = ($urandom_range(0, 19) < 17);
                stall_ID      = ($urandom_range(0, 19) < 3);
                branch_taken  = ($urandom_range(0, 19) == 0);
                jump          = ($urandom_range(0, 29) == 0);
                branch_target = 32'($urandom_range(0, 4095));
                jump_target   = 32'($urandom_range(0, 4095));
                imem_we       = ($urandom_range(0, 9) == 0);
                imem_waddr    = 8'($urandom_range(0, 255));
                imem_wdata    = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
                tick();
                chk("rnd.pc", pc, m_pc);
                chk("rnd.instr", IF_ID_instr, m_instr);
                chk("rnd.pc4", IF_ID_pc4, m_pc4);
                chk("rnd.halted", {31'd0, halted}, {31'd0, m_halted});
                halt_cycles = m_halted ? halt_cycles + 1 : 0;
                if (halt_cycles > 5 || $urandom_range(0, 299) == 0) begin
                    set_idle();
                    do_reset("rnd_rst");
                    halt_cycles = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction memory, and the IF/ID pipeline register.
- Directly upstream of the ID stage and of the hazard detection unit.
- Consumes the HDU's write_pc and stall_ID, plus redirect requests (branch/jump) resolved in ID.
- Produces IF_ID_instr and IF_ID_pc4 for decode.
- Supports debug-unit stepping (enable), instruction-memory loading, and HALT detection.

Parameters:
NB, 32, data/instruction/PC width
IMEM_DEPTH, 256, instruction memory depth in words (power of 2)
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  debug-unit run/step enable; 0 freezes PC, IF/ID and FSM
write_pc  in  1  from HDU; 0 holds PC (load-use stall)
stall_ID  in  1  from HDU; 1 holds IF/ID contents
branch_taken  in  1  ID-resolved branch redirect, already qualified by ID
branch_target  in  NB  branch destination byte address
jump  in  1  ID-resolved jump redirect
jump_target  in  NB  jump destination byte address
imem_we  in  1  debug-unit instruction-memory write strobe
imem_waddr  in  clog2(IMEM_DEPTH)  word address for load
imem_wdata  in  NB  instruction word to load
pc  out  NB  current fetch address
IF_ID_instr  out  NB  instruction latched for ID
IF_ID_pc4  out  NB  PC+4 of latched instruction
halted  out  1  1 once HALT_WORD has been passed to ID

Behaviour:
- Reset (async, rst_n=0): pc=0, IF_ID_instr=0 (NOP), IF_ID_pc4=0, halted=0, FSM=RUN. Memory contents are not cleared.
- Fetch read: imem read is combinational at word address pc[clog2(IMEM_DEPTH)+1:2]. Address wraps modulo IMEM_DEPTH; pc[1:0] is ignored.
- Latency: an instruction fetched in cycle N is visible on IF_ID_instr after edge N+1.
- Memory write: synchronous on imem_we, accepted in any cycle. A same-cycle write to the address being read returns the old word (write visible next cycle).
- Active cycle: adv = enable. With enable=0, nothing except memory writes changes.
- FSM RUN, on each adv edge, evaluated in priority order:
  1. redirect = jump | branch_taken. pc <= jump ? jump_target : branch_target (jump wins if both). IF/ID <= NOP (instr=0, pc4=0). This flush overrides stall_ID and write_pc.
  2. Else if fetched word == HALT_WORD and stall_ID=0: IF_ID_instr <= HALT_WORD, IF_ID_pc4 <= pc+4, pc unchanged, FSM -> HALTED, halted <= 1.
  3. Else:
     - pc <= write_pc ? pc+4 : pc (modulo 2^NB).
     - IF/ID <= stall_ID ? hold : {imem[pc], pc+4}.
- HALT fetched while stall_ID=1: held like any other fetch, no halt yet; re-evaluated on the next adv edge.
- FSM HALTED:
  - pc frozen; redirects and write_pc ignored.
  - Each adv edge with stall_ID=0 loads NOP into IF/ID, so HALT reaches ID exactly once and the pipeline drains. stall_ID=1 holds IF/ID.
  - Exit only via rst_n.
- Reset mid-operation: immediate return to reset values, independent of clk/enable.
- halted is registered, asserted on the same edge that latches HALT_WORD.

Test Plan:
- Load 0x20010005,0x20020007,0xFFFFFFFF at words 0..2, enable=1 -> IF_ID_instr 0x20010005/pc4=4, then 0x20020007/pc4=8, then HALT/pc4=12 with halted=1, pc=8 frozen; next cycles IF_ID_instr=0.
- Mid-run, write_pc=0 and stall_ID=1 for 2 cycles at pc=8 -> pc stays 8, IF/ID holds prior word; release -> fetch resumes at 8 with no skipped or duplicated instruction.
- branch_taken=1, branch_target=0x40, with stall_ID=1 in the same cycle -> pc=0x40, IF_ID_instr=0 next edge; following edge latches imem[16].
- jump=1 (0x80) and branch_taken=1 (0x40) together -> pc=0x80.
- enable=0 for 3 cycles while imem_we loads words -> pc/IF_ID/halted unchanged; then a single enable pulse advances exactly one instruction.
- rst_n=0 asynchronously while halted -> all outputs 0 before next clk edge; after release, fetch restarts at pc=0.
